// File: rtl/usb_tx_scheduler.sv
// Packet scheduler for the FT232H transmit path: picks the next 500-byte packet
// (RX IQ block or wide-bandscope burst packet) and hands it to the byte writer.
module usb_tx_scheduler #(
    parameter int BS_PACKETS   = 67,
    parameter int NBS_PACKETS  = 67,
    parameter int RX_BURST_MAX = 4
) (
    input  logic       usb_clock,
    input  logic       reset,
    input  logic       rx_on,
    input  logic       bs_on,
    input  logic       nbs_on,
    input  logic       nbs_start,
    input  logic       rx_block_tgl,
    input  logic       bs_ready_tgl,
    input  logic       rd_active,
    input  logic       pkt_ack,
    input  logic       pkt_done,
    output logic       pkt_req,
    output logic [1:0] pkt_type,
    output logic [7:0] pkt_pn,
    output logic       rx_blk,
    output logic       bs_addr_rst,
    output logic [7:0] rx_overrun,
    output logic       busy
);

    localparam int              SW         = $clog2(RX_BURST_MAX + 1);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(RX_BURST_MAX);
    localparam logic [7:0]      NBS_LIMIT  = 8'(NBS_PACKETS);
    localparam logic [7:0]      BS_LAST    = 8'(BS_PACKETS - 1);
    localparam logic [1:0]      TYPE_NONE  = 2'b00;
    localparam logic [1:0]      TYPE_RX    = 2'b01;
    localparam logic [1:0]      TYPE_BS    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

    state_t          state_reg;
    logic            rx_seen_reg;
    logic            bs_seen_reg;
    logic            rx_pend_reg;
    logic            rx_blk_next_reg;
    logic            bs_active_reg;
    logic [7:0]      bs_pn_reg;
    logic [7:0]      nbs_pn_reg;
    logic [SW-1:0]   rx_streak_reg;

    logic in_idle;
    logic in_req;
    logic in_busy;
    logic rx_event;
    logic bs_event;
    logic rx_elig;
    logic bs_go;
    logic rx_drop;
    logic rx_taken;
    logic bs_abort;
    logic done_rx;
    logic done_bs;
    logic grant_rx;
    logic grant_bs;

    assign in_idle  = (state_reg == ST_IDLE);
    assign in_req   = (state_reg == ST_REQ);
    assign in_busy  = (state_reg == ST_BUSY);

    assign rx_event = rx_block_tgl ^ rx_seen_reg;
    assign bs_event = (bs_ready_tgl ^ bs_seen_reg) & ~bs_active_reg;

    // Narrow-bandscope mode only lets RX through inside the window, up to the quota.
    assign rx_elig  = rx_pend_reg & (~nbs_on | (nbs_start & (nbs_pn_reg < NBS_LIMIT)));
    assign bs_go    = bs_active_reg & bs_on;
    assign rx_drop  = in_idle & nbs_on & rx_pend_reg & ~rx_elig;
    assign rx_taken = in_req & pkt_ack & (pkt_type == TYPE_RX);
    assign bs_abort = in_idle & bs_active_reg & ~bs_on;
    assign done_rx  = in_busy & pkt_done & (pkt_type == TYPE_RX);
    assign done_bs  = in_busy & pkt_done & (pkt_type == TYPE_BS);

    // RX wins until it has had RX_BURST_MAX packets in a row against a pending burst.
    assign grant_rx = in_idle & ~rd_active & rx_elig & (~bs_go | (rx_streak_reg < STREAK_MAX));
    assign grant_bs = in_idle & ~rd_active & ~grant_rx & bs_go;

    always_ff @(posedge usb_clock or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            rx_seen_reg     <= 1'b0;
            bs_seen_reg     <= 1'b0;
            rx_pend_reg     <= 1'b0;
            rx_blk_next_reg <= 1'b0;
            bs_active_reg   <= 1'b0;
            bs_pn_reg       <= 8'd0;
            nbs_pn_reg      <= 8'd0;
            rx_streak_reg   <= '0;
            pkt_req         <= 1'b0;
            pkt_type        <= TYPE_NONE;
            pkt_pn          <= 8'd0;
            rx_blk          <= 1'b0;
            bs_addr_rst     <= 1'b0;
            rx_overrun      <= 8'd0;
            busy            <= 1'b0;
        end else begin
            bs_addr_rst <= 1'b0;

            // A block arriving in the same cycle it is consumed or dropped re-arms rx_pend.
            if (rx_taken || rx_drop) begin
                rx_pend_reg <= 1'b0;
            end
            if (rx_event) begin
                rx_seen_reg <= rx_block_tgl;
                if (rx_on) begin
                    rx_pend_reg     <= 1'b1;
                    rx_blk_next_reg <= rx_block_tgl;
                    if (rx_pend_reg && !rx_taken && !rx_drop && (rx_overrun != 8'hFF)) begin
                        rx_overrun <= rx_overrun + 8'd1;
                    end
                end
            end

            if (!nbs_on) begin
                nbs_pn_reg <= 8'd0;
            end else if (!nbs_start && (nbs_pn_reg == NBS_LIMIT)) begin
                nbs_pn_reg <= 8'd0;
            end else if (done_rx) begin
                nbs_pn_reg <= nbs_pn_reg + 8'd1;
            end

            if (bs_event) begin
                if (bs_on) begin
                    bs_active_reg <= 1'b1;
                    bs_pn_reg     <= 8'd0;
                end else begin
                    bs_seen_reg <= bs_ready_tgl;
                end
            end

            // Ending a burst consumes only the toggle that opened it, so an odd
            // number of toggles seen during the burst surfaces as a fresh capture.
            if (bs_abort) begin
                bs_active_reg <= 1'b0;
                bs_seen_reg   <= ~bs_seen_reg;
                bs_addr_rst   <= 1'b1;
            end

            if (!bs_active_reg || done_bs) begin
                rx_streak_reg <= '0;
            end else if (done_rx && (rx_streak_reg != STREAK_MAX)) begin
                rx_streak_reg <= rx_streak_reg + SW'(1);
            end

            case (state_reg)
                ST_IDLE: begin
                    if (grant_rx) begin
                        pkt_req   <= 1'b1;
                        pkt_type  <= TYPE_RX;
                        pkt_pn    <= nbs_pn_reg;
                        rx_blk    <= rx_blk_next_reg;
                        busy      <= 1'b1;
                        state_reg <= ST_REQ;
                    end else if (grant_bs) begin
                        pkt_req   <= 1'b1;
                        pkt_type  <= TYPE_BS;
                        pkt_pn    <= bs_pn_reg;
                        busy      <= 1'b1;
                        state_reg <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (pkt_ack) begin
                        pkt_req   <= 1'b0;
                        state_reg <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (pkt_done) begin
                        if (pkt_type == TYPE_BS) begin
                            if (bs_pn_reg == BS_LAST) begin
                                bs_pn_reg     <= 8'd0;
                                bs_active_reg <= 1'b0;
                                bs_seen_reg   <= ~bs_seen_reg;
                                bs_addr_rst   <= 1'b1;
                            end else begin
                                bs_pn_reg <= bs_pn_reg + 8'd1;
                            end
                        end
                        pkt_type  <= TYPE_NONE;
                        busy      <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    pkt_req   <= 1'b0;
                    pkt_type  <= TYPE_NONE;
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Scoreboard bench for usb_tx_scheduler: expected grants are queued as stimulus
// is driven and checked in order as the scheduler raises pkt_req.
module tb_usb_tx_scheduler;

    localparam logic [1:0] T_RX = 2'b01;
    localparam logic [1:0] T_BS = 2'b10;

    typedef struct packed {
        logic [1:0] typ;
        logic [7:0] pn;
        logic       blk;
    } exp_t;

    logic       usb_clock;
    logic       reset;
    logic       rx_on;
    logic       bs_on;
    logic       nbs_on;
    logic       nbs_start;
    logic       rx_block_tgl;
    logic       bs_ready_tgl;
    logic       rd_active;
    logic       pkt_ack;
    logic       pkt_done;
    logic       pkt_req;
    logic [1:0] pkt_type;
    logic [7:0] pkt_pn;
    logic       rx_blk;
    logic       bs_addr_rst;
    logic [7:0] rx_overrun;
    logic       busy;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   rst_pulses = 0;

    usb_tx_scheduler #(
        .BS_PACKETS  (67),
        .NBS_PACKETS (67),
        .RX_BURST_MAX(4)
    ) dut (
        .usb_clock   (usb_clock),
        .reset       (reset),
        .rx_on       (rx_on),
        .bs_on       (bs_on),
        .nbs_on      (nbs_on),
        .nbs_start   (nbs_start),
        .rx_block_tgl(rx_block_tgl),
        .bs_ready_tgl(bs_ready_tgl),
        .rd_active   (rd_active),
        .pkt_ack     (pkt_ack),
        .pkt_done    (pkt_done),
        .pkt_req     (pkt_req),
        .pkt_type    (pkt_type),
        .pkt_pn      (pkt_pn),
        .rx_blk      (rx_blk),
        .bs_addr_rst (bs_addr_rst),
        .rx_overrun  (rx_overrun),
        .busy        (busy)
    );

    initial begin
        usb_clock = 1'b0;
        forever #5 usb_clock = ~usb_clock;
    end

    always @(negedge usb_clock) begin
        if (bs_addr_rst === 1'b1) rst_pulses <= rst_pulses + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [1:0] typ, input logic [7:0] pn, input logic blk);
        exp_t e;
        e.typ = typ;
        e.pn  = pn;
        e.blk = blk;
        sb_q.push_back(e);
    endtask

    function automatic logic [31:0] outs();
        return 32'({pkt_req, pkt_type, pkt_pn, rx_blk, bs_addr_rst, rx_overrun, busy});
    endfunction

    task automatic wait_grant(output bit ok, output exp_t e);
        int n = 0;
        ok = 1'b0;
        e  = '0;
        while (pkt_req !== 1'b1 && n < 300) begin
            @(negedge usb_clock);
            n++;
        end
        chk("req_seen", 32'(pkt_req), 32'd1);
        if (pkt_req !== 1'b1) return;
        ok = 1'b1;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'(sb_q.size()), 32'd1);
            return;
        end
        e = sb_q.pop_front();
        $display("grant type=%0d pn=%0d blk=%0d overrun=%0d", pkt_type, pkt_pn, rx_blk, rx_overrun);
        chk("grant_type_pn", 32'({pkt_type, pkt_pn}), 32'({e.typ, e.pn}));
        if (e.typ == T_RX) chk("grant_blk", 32'(rx_blk), 32'(e.blk));
        chk("busy_in_req", 32'(busy), 32'd1);
    endtask

    task automatic finish_pkt(input logic [1:0] typ, input bit refill);
        repeat (2) @(negedge usb_clock);
        chk("req_hold", 32'({pkt_req, pkt_type}), 32'({1'b1, typ}));
        pkt_ack = 1'b1;
        @(negedge usb_clock);
        pkt_ack = 1'b0;
        chk("ack_to_busy", 32'({pkt_req, busy}), 32'b01);
        if (refill) rx_block_tgl = ~rx_block_tgl;
        repeat (3) @(negedge usb_clock);
        pkt_done = 1'b1;
        @(negedge usb_clock);
        pkt_done = 1'b0;
        chk("done_to_idle", 32'({pkt_req, busy, pkt_type}), 32'd0);
    endtask

    task automatic serve(input bit refill);
        bit   ok;
        exp_t e;
        wait_grant(ok, e);
        if (ok) finish_pkt(e.typ, refill && (e.typ == T_RX));
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        logic seen = 1'b0;
        repeat (cycles) begin
            @(negedge usb_clock);
            if (pkt_req !== 1'b0) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        bit         ok;
        exp_t       e;
        logic       t;
        int         p0;

        reset = 1'b0; rx_on = 1'b0; bs_on = 1'b0; nbs_on = 1'b0; nbs_start = 1'b0;
        rx_block_tgl = 1'b0; bs_ready_tgl = 1'b0; rd_active = 1'b0;
        pkt_ack = 1'b0; pkt_done = 1'b0;
        repeat (3) @(negedge usb_clock);
        chk("reset_outputs", outs(), 32'd0);
        reset = 1'b1;
        expect_quiet("idle_after_reset", 5);

        // RX only
        rx_on = 1'b1;
        rx_block_tgl = 1'b1;
        push_exp(T_RX, 8'd0, 1'b1);
        serve(1'b0);
        chk("rx_only_overrun", 32'(rx_overrun), 32'd0);

        // Narrow bandscope: quota of 67, then drops without overrun, window reopen
        nbs_on = 1'b1;
        nbs_start = 1'b1;
        for (int i = 0; i < 70; i++) begin
            rx_block_tgl = ~rx_block_tgl;
            if (i < 67) begin
                push_exp(T_RX, 8'(i), rx_block_tgl);
                serve(1'b0);
            end else begin
                expect_quiet("nbs_drop", 8);
            end
        end
        chk("nbs_no_overrun", 32'(rx_overrun), 32'd0);
        nbs_start = 1'b0;
        repeat (3) @(negedge usb_clock);
        nbs_start = 1'b1;
        rx_block_tgl = ~rx_block_tgl;
        push_exp(T_RX, 8'd0, rx_block_tgl);
        serve(1'b0);
        nbs_on = 1'b0;
        nbs_start = 1'b0;

        // Wide-bandscope burst of 67 packets
        bs_on = 1'b1;
        bs_ready_tgl = ~bs_ready_tgl;
        p0 = rst_pulses;
        for (int i = 0; i < 67; i++) push_exp(T_BS, 8'(i), 1'b0);
        for (int i = 0; i < 67; i++) begin
            if (i == 66) chk("bs_rst_early", 32'(rst_pulses - p0), 32'd0);
            serve(1'b0);
        end
        expect_quiet("bs_burst_over", 10);
        chk("bs_rst_pulse", 32'(rst_pulses - p0), 32'd1);

        // Fairness: RX x4 then BS while a burst is pending
        rd_active = 1'b1;
        bs_ready_tgl = ~bs_ready_tgl;
        rx_block_tgl = ~rx_block_tgl;
        t = rx_block_tgl;
        for (int g = 0; g < 15; g++) begin
            if (g % 5 == 4) begin
                push_exp(T_BS, 8'(g / 5), 1'b0);
            end else begin
                push_exp(T_RX, 8'd0, t);
                t = ~t;
            end
        end
        repeat (4) @(negedge usb_clock);
        chk("fair_holdoff", 32'(pkt_req), 32'd0);
        rd_active = 1'b0;
        p0 = rst_pulses;
        for (int g = 0; g < 15; g++) serve(1'b1);
        bs_on = 1'b0;
        push_exp(T_RX, 8'd0, t);
        serve(1'b0);
        expect_quiet("fair_end", 10);
        chk("bs_abort_pulse", 32'(rst_pulses - p0), 32'd1);
        chk("fair_no_overrun", 32'(rx_overrun), 32'd0);

        // Overrun: two toggles before a grant, then saturation
        rd_active = 1'b1;
        rx_block_tgl = ~rx_block_tgl;
        repeat (2) @(negedge usb_clock);
        rx_block_tgl = ~rx_block_tgl;
        repeat (2) @(negedge usb_clock);
        chk("overrun_one", 32'(rx_overrun), 32'd1);
        chk("overrun_holdoff", 32'(pkt_req), 32'd0);
        push_exp(T_RX, 8'd0, rx_block_tgl);
        rd_active = 1'b0;
        serve(1'b0);
        rd_active = 1'b1;
        for (int i = 0; i < 301; i++) begin
            rx_block_tgl = ~rx_block_tgl;
            repeat (2) @(negedge usb_clock);
        end
        chk("overrun_sat", 32'(rx_overrun), 32'd255);
        push_exp(T_RX, 8'd0, rx_block_tgl);
        rd_active = 1'b0;
        serve(1'b0);

        // Hold-off, then asynchronous reset while BUSY
        rx_on = 1'b0;
        rx_block_tgl = 1'b0;
        repeat (3) @(negedge usb_clock);
        rx_on = 1'b1;
        rd_active = 1'b1;
        rx_block_tgl = 1'b1;
        expect_quiet("rd_holdoff", 10);
        push_exp(T_RX, 8'd0, 1'b1);
        rd_active = 1'b0;
        wait_grant(ok, e);
        if (ok) begin
            pkt_ack = 1'b1;
            @(negedge usb_clock);
            pkt_ack = 1'b0;
            repeat (2) @(negedge usb_clock);
            chk("busy_before_reset", 32'(busy), 32'd1);
        end
        #2 reset = 1'b0;
        #1 chk("reset_async", outs(), 32'd0);
        repeat (2) @(negedge usb_clock);
        reset = 1'b1;
        push_exp(T_RX, 8'd0, 1'b1);
        serve(1'b0);
        chk("post_reset_overrun", 32'(rx_overrun), 32'd0);
        expect_quiet("final_idle", 10);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
